// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad event path.
//   kp_state_t       - debounce FSM states
//   KEY_0..KEY_F     - key codes, matching the column scanner encoding
//   DEBOUNCE_DEFAULT - default debounce length (10 ms at 100 MHz)
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} kp_state_t;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  localparam int DEBOUNCE_DEFAULT = 1_000_000;

endpackage

// File: rtl/kp_sync_fifo.sv
// kp_sync_fifo: small synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   push       - write request, push_data is the entry
//   pop        - read strobe; the head is removed at the clock edge
//   rd_data    - oldest entry (forced to 0 while empty)
//   full/empty - occupancy status, derived from count
//   count      - number of stored entries
//   drop       - a push is being discarded this cycle (full, no pop)
module kp_sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);

  // Tiny storage; a combinational read is needed so the head is visible
  // in the cycle it becomes oldest.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             pop_eff;
  logic             push_eff;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign pop_eff  = pop & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_eff = push & (~full | pop_eff);
  assign drop     = push & full & ~pop_eff;
  assign count    = count_reg;
  assign rd_data  = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally; count alone decides full/empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo: debounces the scanner's "any key pressed" flag, emits
// one key-code event per debounced press (no auto-repeat) and queues the
// codes in a FWFT FIFO read by the CPU.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   key_in      - scanner key code
//   pressed_in  - scanner per-column pressed flags
//   pop         - CPU read strobe
//   clr_ovf     - clears the sticky overflow flag
//   rd_data     - FIFO head (valid while empty=0)
//   empty/count - FIFO status
//   overflow    - sticky: a press was lost to a full FIFO
//   irq         - registered ~empty
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int DEPTH           = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             key_in,
  input  logic [3:0]             pressed_in,
  input  logic                   pop,
  input  logic                   clr_ovf,
  output logic [3:0]             rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   irq
);

  localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 1);

  logic [3:0]  pressed_reg;
  logic [3:0]  key_reg;
  logic        any_p;
  kp_state_t   state_reg;
  logic [23:0] cnt_reg;
  logic        push_reg;
  logic [3:0]  push_key_reg;
  logic        overflow_reg;
  logic        irq_reg;
  logic        fifo_empty;
  logic        fifo_drop;
  logic        fifo_full_unused;

  assign any_p = |pressed_reg;

  // Single-process FSM. The push is a registered strobe issued on entry to
  // HELD, carrying the key code seen in that same cycle; the FIFO writes it
  // one edge later. The ">=" compare makes DEBOUNCE_CYCLES=1 accept on the
  // first qualifying cycle and is identical to "==" for larger values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pressed_reg  <= '0;
      key_reg      <= '0;
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      push_reg     <= 1'b0;
      push_key_reg <= '0;
      overflow_reg <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      pressed_reg <= pressed_in;
      key_reg     <= key_in;
      push_reg    <= 1'b0;
      irq_reg     <= ~fifo_empty;

      // Set wins over clear.
      if (fifo_drop)    overflow_reg <= 1'b1;
      else if (clr_ovf) overflow_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (any_p) begin
            state_reg <= PRESS_WAIT;
            cnt_reg   <= 24'd1;
          end
        end
        PRESS_WAIT: begin
          if (!any_p) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg >= CNT_LAST) begin
            state_reg    <= HELD;
            cnt_reg      <= '0;
            push_reg     <= 1'b1;
            push_key_reg <= key_reg;
          end else begin
            cnt_reg <= cnt_reg + 24'd1;
          end
        end
        HELD: begin
          if (!any_p) begin
            state_reg <= REL_WAIT;
            cnt_reg   <= 24'd1;
          end
        end
        REL_WAIT: begin
          if (any_p) begin
            state_reg <= HELD;
            cnt_reg   <= '0;
          end else if (cnt_reg >= CNT_LAST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 24'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // The full flag is not needed here: drop already covers the full case.
  kp_sync_fifo #(
    .WIDTH (4),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_reg),
    .push_data (push_key_reg),
    .pop       (pop),
    .rd_data   (rd_data),
    .full      (fifo_full_unused),
    .empty     (fifo_empty),
    .count     (count),
    .drop      (fifo_drop)
  );

  assign empty    = fifo_empty;
  assign overflow = overflow_reg;
  assign irq      = irq_reg;

endmodule

// File: tb/tb_keypad_event_fifo.sv
module tb_keypad_event_fifo;
  import keypad_pkg::*;

  localparam int D     = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] pressed_in;
  logic       pop;
  logic       clr_ovf;
  logic [3:0] rd_data;
  logic       empty;
  logic [2:0] count;
  logic       overflow;
  logic       irq;

  int checks = 0;
  int errors = 0;

  keypad_event_fifo #(.DEBOUNCE_CYCLES(D), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .pressed_in (pressed_in),
    .pop        (pop),
    .clr_ovf    (clr_ovf),
    .rd_data    (rd_data),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A press event fires when the (one-cycle delayed) any-pressed level has
  // been 1 for D consecutive cycles while armed; re-arming needs D
  // consecutive cycles of 0. Events reach the queue one cycle later.
  logic [3:0] mq[$];
  logic [3:0] p_d, k_d, pend_key;
  logic       last_any, armed, pend, m_ovf, m_irq;
  int         run_len;
  bit         mon_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      p_d = 0; k_d = 0; pend = 0; pend_key = 0;
      last_any = 0; armed = 1; run_len = 0;
      m_ovf = 0; m_irq = 0;
    end else begin
      logic cur_any;
      logic dropped;
      m_irq = (mq.size() != 0);
      dropped = 0;
      if (pop && mq.size() != 0) void'(mq.pop_front());
      if (pend) begin
        if (mq.size() < DEPTH) mq.push_back(pend_key);
        else dropped = 1;
      end
      if (dropped) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;

      cur_any = |p_d;
      if (cur_any == last_any) run_len++;
      else run_len = 1;
      last_any = cur_any;
      pend = 0;
      if (armed && cur_any && run_len == D) begin
        pend = 1; pend_key = k_d; armed = 0;
      end else if (!armed && !cur_any && run_len == D) begin
        armed = 1;
      end
      p_d = pressed_in;
      k_d = key_in;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("count", 32'(count), 32'(mq.size()));
      check("empty", 32'(empty), 32'(mq.size() == 0));
      check("irq", 32'(irq), 32'(m_irq));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("rd_data", 32'(rd_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int rel);
    key_in     = code;
    pressed_in = 4'($urandom_range(1, 15));
    repeat (hold) tick();
    pressed_in = 4'h0;
    repeat (rel) tick();
  endtask

  // Ticks until empty falls, bounded; returns cycles taken.
  task automatic measure(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (empty && n < 100);
  endtask

  initial begin
    int n;
    logic [3:0] codes [5];
    logic [3:0] fill  [4];
    logic [3:0] newc;

    rst = 1'b1; key_in = 0; pressed_in = 0; pop = 0; clr_ovf = 0;
    repeat (2) tick();
    rst = 1'b0;
    mon_en = 1;
    tick();

    // 1: reset state
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);

    // 2: single clean press, latency and single entry
    key_in = KEY_5; pressed_in = 4'b0010;
    measure(n);
    check("latency", 32'(n), 32'(D + 2));
    repeat (40 - n) tick();
    check("s2_rd_data", 32'(rd_data), 32'h5);
    check("s2_count", 32'(count), 32'd1);
    pressed_in = 0;
    repeat (40) tick();
    check("s2_single", 32'(count), 32'd1);
    do_pop();
    check("s2_pop_empty", 32'(empty), 32'd1);

    // 3: bounce shorter than the debounce window
    for (int i = 0; i < 25; i++) begin
      pressed_in = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      repeat (8) tick();
    end
    pressed_in = 0;
    repeat (20) tick();
    check("s3_no_push", 32'(count), 32'd0);

    // 4: overflow with five presses into a 4-deep FIFO
    codes[0] = KEY_1; codes[1] = KEY_2; codes[2] = KEY_3;
    codes[3] = KEY_A; codes[4] = KEY_D;
    for (int i = 0; i < 5; i++) press(codes[i], 20, 20);
    check("s4_count", 32'(count), 32'd4);
    check("s4_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("s4_order", 32'(rd_data), 32'(codes[i]));
      do_pop();
    end
    check("s4_drained", 32'(empty), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("s4_clr_ovf", 32'(overflow), 32'd0);

    // 5: push and pop in the same cycle while full
    for (int i = 0; i < 4; i++) begin
      fill[i] = 4'($urandom_range(0, 15));
      press(fill[i], 20, 20);
    end
    check("s5_full", 32'(count), 32'd4);
    newc = 4'($urandom_range(0, 15));
    key_in = newc; pressed_in = 4'b1000;
    repeat (D + 1) tick();
    pop = 1'b1;          // coincides with the push edge
    tick();
    pop = 1'b0;
    check("s5_count", 32'(count), 32'd4);
    check("s5_ovf", 32'(overflow), 32'd0);
    repeat (4) tick();
    pressed_in = 0;
    repeat (20) tick();
    for (int i = 1; i < 4; i++) begin
      check("s5_order", 32'(rd_data), 32'(fill[i]));
      do_pop();
    end
    check("s5_tail", 32'(rd_data), 32'(newc));
    do_pop();
    check("s5_drained", 32'(empty), 32'd1);

    // 6: reset mid-debounce, fresh debounce after release of reset
    key_in = 4'($urandom_range(0, 15)); pressed_in = 4'b0001;
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    measure(n);
    check("s6_latency", 32'(n), 32'(D + 2));
    repeat (40 - n) tick();
    pressed_in = 0;
    repeat (20) tick();
    check("s6_count", 32'(count), 32'd1);
    do_pop();

    // Random phase: presses of random length, random pops and clears.
    for (int t = 0; t < 40; t++) begin
      int hold, rel;
      key_in = 4'($urandom_range(0, 15));
      pressed_in = 4'($urandom_range(1, 15));
      hold = $urandom_range(5, 30);
      rel  = $urandom_range(5, 30);
      for (int c = 0; c < hold + rel; c++) begin
        if (c == hold) pressed_in = 0;
        pop     = ($urandom_range(0, 5) == 0);
        clr_ovf = ($urandom_range(0, 20) == 0);
        tick();
      end
      pop = 0; clr_ovf = 0;
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_event_fifo.md
Name: keypad_event_fifo

Overview:
- Sits directly downstream of the 4x4 keypad column scanner.
- Consumes the scanner's 4-bit key code and its per-column pressed flags, and debounces "any key pressed".
- Emits one event per debounced press, with no auto-repeat.
- Buffers the key codes in a small FIFO that the SOPC CPU reads through a pop strobe, and raises an interrupt while the FIFO is non-empty.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, number of consecutive clk cycles the pressed state must hold before it is accepted (10 ms at 100 MHz). Legal range 1..2^24-1.
- DEPTH, 8, FIFO depth in entries. Must be a power of two, 2..64.

Ports:
- clk  input  1  100 MHz system clock, the same clock as the scanner.
- rst  input  1  synchronous, active-high reset.
- key_in  input  4  scanner key code, bits [3:0] of the scanner's key word.
- pressed_in  input  4  scanner per-column pressed flags, bits [3:0] of the scanner's released word.
- pop  input  1  one-cycle read strobe from the CPU.
- clr_ovf  input  1  one-cycle strobe that clears the overflow flag.
- rd_data  output  4  FIFO head key code. Valid only while empty=0.
- empty  output  1  FIFO holds no entries.
- count  output  $clog2(DEPTH)+1  number of stored entries.
- overflow  output  1  sticky flag: a press was lost because the FIFO was full.
- irq  output  1  equals ~empty, registered.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; debounce counter, FIFO pointers and count go to 0.
  - empty=1, overflow=0, irq=0, rd_data=0.
  - Reset mid-debounce or with a full FIFO discards everything; no event is emitted.
- Inputs are registered once before use.
  - any_p = |pressed_q, where pressed_q is the registered pressed_in. key_q is the registered key_in.
- Debounce FSM, counter cnt is 24 bits:
  - IDLE: if any_p=1, go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT:
    - if any_p=0, return to IDLE with cnt=0;
    - else if cnt==DEBOUNCE_CYCLES-1, go to HELD and push key_q;
    - else cnt++.
  - HELD: if any_p=0, go to REL_WAIT with cnt=1. No repeat pushes occur while held.
  - REL_WAIT:
    - if any_p=1, return to HELD with cnt=0;
    - else if cnt==DEBOUNCE_CYCLES-1, go to IDLE;
    - else cnt++.
  - DEBOUNCE_CYCLES=1: the transition occurs on the first qualifying cycle.
  - The pushed code is key_q in the same cycle the FSM enters HELD.
- Latency:
  - From pressed_in rising (held steady) to empty falling is DEBOUNCE_CYCLES+2 clk cycles.
  - irq follows empty one cycle later.
- FIFO is first-word-fall-through:
  - rd_data always shows the oldest entry.
  - pop takes effect at the clk edge; the next entry appears the following cycle.
- Boundary conditions:
  - pop while empty=1: ignored; count does not underflow.
  - Push while full and no pop: the entry is dropped and overflow is set to 1.
  - Push and pop in the same cycle when not empty: both happen and count is unchanged. This includes the full case: the pop frees the slot, so nothing is dropped.
  - Push and pop in the same cycle when empty: the push happens and the pop is ignored.
  - Pointer wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. count is the full/empty authority.
- overflow:
  - Set by a dropped push and cleared by clr_ovf.
  - If both occur in the same cycle, set wins.
- A second key pressed while the first is held produces no new event (any_p stays 1). Release both keys, then press again, to register.

Decomposition:
- keypad_pkg holds:
  - the typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} kp_state_t;
  - key-code localparams KEY_0..KEY_9 and KEY_A..KEY_F (4'h0..4'hF, matching the scanner encoding);
  - the localparam DEBOUNCE_DEFAULT = 1_000_000.
- One sub-module, kp_sync_fifo (parameters WIDTH, DEPTH; FWFT; push/pop/full/empty/count/drop). The debounce FSM and the overflow flag stay in the top level.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=16 and DEPTH=4.
1. rst for 2 cycles, then idle -> empty=1, count=0, irq=0, overflow=0, rd_data=0.
2. key_in=4'h5, pressed_in=4'b0010 held 40 cycles, then 0 for 40 cycles -> empty falls exactly 18 cycles after the stimulus edge. rd_data=5, count=1, a single entry only. One pop -> empty=1.
3. pressed_in toggles 1/0 every 8 cycles for 200 cycles -> no push, count stays 0.
4. Five clean presses with codes 1, 2, 3, 0xA, 0xD and no pops -> count=4, overflow=1. Pops return 1, 2, 3, 0xA in order. clr_ovf -> overflow=0.
5. FIFO full; push and pop in the same cycle -> count stays 4, overflow stays 0, the new code lands at the tail.
6. rst asserted in PRESS_WAIT at cnt=10, then the key is held 40 more cycles -> a push still occurs only after a fresh 16-cycle debounce, measured from rst release. Exactly one entry results.
